// File: rtl/fp32_iterative_multiplier.sv
// Multi-cycle FP32 multiplier: one shift-add step per clock on the 24-bit significands,
// truncating rounding, denormals flushed to zero, exponent 255 treated as infinity.
module fp32_iterative_multiplier #(
  parameter int MANT_W = 24,
  parameter int BIAS   = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result,
  output logic        OVF,
  output logic        UFF
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  localparam int          PROD_W = 2 * MANT_W;
  localparam logic [4:0]  LAST_STEP = 5'(MANT_W - 1);
  localparam logic signed [9:0] BIAS_S = 10'(BIAS);

  state_t state, state_next;

  logic                    sign;
  logic signed [9:0]       exp_sum;
  logic [MANT_W-1:0]       ma, mb;
  logic [PROD_W-1:0]       product;
  logic [4:0]              counter;

  logic [7:0]              exp_a, exp_b;
  logic                    in_sign, any_inf, any_zero;
  logic [MANT_W:0]         acc;
  logic [PROD_W-1:0]       product_step;
  logic signed [9:0]       e_norm;
  logic [22:0]             mant_norm;

  assign exp_a    = OperandA[30:23];
  assign exp_b    = OperandB[30:23];
  assign in_sign  = OperandA[31] ^ OperandB[31];
  assign any_inf  = (exp_a == 8'hFF) || (exp_b == 8'hFF);
  assign any_zero = (exp_a == 8'h00) || (exp_b == 8'h00);

  // Add into the upper half with the carry kept, then shift {carry, product} right.
  assign acc          = {1'b0, product[PROD_W-1 -: MANT_W]} + {1'b0, (mb[0] ? ma : {MANT_W{1'b0}})};
  assign product_step = {acc, product[MANT_W-1:1]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    e_norm    = exp_sum - BIAS_S;
    mant_norm = product[PROD_W-3 -: 23];
    if (product[PROD_W-1]) begin
      e_norm    = exp_sum - BIAS_S + 10'sd1;
      mant_norm = product[PROD_W-2 -: 23];
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (Start) state_next = (any_inf || any_zero) ? DONE : MUL;
      MUL:  if (counter == LAST_STEP) state_next = NORM;
      NORM: state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and also clears the datapath so a mid-operation abort leaves no stale state.
    if (rst) begin
      state   <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Result  <= 32'h0;
      OVF     <= 1'b0;
      UFF     <= 1'b0;
      sign    <= 1'b0;
      exp_sum <= 10'sd0;
      ma      <= '0;
      mb      <= '0;
      product <= '0;
      counter <= 5'd0;
    end else begin
      state <= state_next;
      Busy  <= (state_next != IDLE);
      Done  <= (state_next == DONE);
      unique case (state)
        IDLE: if (Start) begin
          sign    <= in_sign;
          exp_sum <= $signed({2'b00, exp_a}) + $signed({2'b00, exp_b});
          ma      <= {1'b1, OperandA[22:0]};
          mb      <= {1'b1, OperandB[22:0]};
          product <= '0;
          counter <= 5'd0;
          if (any_inf) begin
            Result <= {in_sign, 8'hFF, 23'h0};
            OVF    <= 1'b0;
            UFF    <= 1'b0;
          end else if (any_zero) begin
            Result <= {in_sign, 31'h0};
            OVF    <= 1'b0;
            UFF    <= 1'b0;
          end
        end
        MUL: begin
          product <= product_step;
          mb      <= mb >> 1;
          counter <= counter + 5'd1;
        end
        NORM: begin
          if (e_norm >= 10'sd255) begin
            Result <= {sign, 8'hFF, 23'h0};
            OVF    <= 1'b1;
            UFF    <= 1'b0;
          end else if (e_norm <= 10'sd0) begin
            Result <= {sign, 31'h0};
            OVF    <= 1'b0;
            UFF    <= 1'b1;
          end else begin
            Result <= {sign, e_norm[7:0], mant_norm};
            OVF    <= 1'b0;
            UFF    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_iterative_multiplier.sv
// Directed bench for fp32_iterative_multiplier with hand-computed products, latencies and flags.
module tb_fp32_iterative_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] opa, opb;
  logic        busy, done;
  logic [31:0] result;
  logic        ovf, uff;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fp32_iterative_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (start),
    .OperandA (opa),
    .OperandB (opb),
    .Busy     (busy),
    .Done     (done),
    .Result   (result),
    .OVF      (ovf),
    .UFF      (uff)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge where Done is seen (or on timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output logic busy_ok);
    start = 1'b1; opa = a; opb = b;
    @(posedge clk); lat = 1;
    @(negedge clk); start = 1'b0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (!busy) busy_ok = 1'b0;
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; opa = 32'h0; opb = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    total_cnt++;
    if ({busy, done, result, ovf, uff} !== 36'h0)
      $display("FAIL reset_state: got busy=%b done=%b result=%h ovf=%b uff=%b expected all 0",
               busy, done, result, ovf, uff);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat; logic bok;
    run_op(32'h3FC00000, 32'h40000000, lat, bok);
    chk32("basic_result", result, 32'h40400000);
    total_cnt++;
    if ({ovf, uff} !== 2'b00) $display("FAIL basic_flags: got %b%b expected 00", ovf, uff);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 26) $display("FAIL basic_latency: got %0d expected 26", lat);
    else pass_cnt++;
    total_cnt++;
    if (bok !== 1'b1) $display("FAIL basic_busy: got busy dropped expected held high");
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat; logic bok;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if ({done, busy} !== 2'b00) $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    else pass_cnt++;
    run_op(32'hC0200000, 32'h40800000, lat, bok);
    chk32("neg_result", result, 32'hC1200000);
    @(posedge clk); @(negedge clk);
    run_op(32'h3FFFFFFF, 32'h3FFFFFFF, lat, bok);
    chk32("trunc_result", result, 32'h407FFFFE);
    total_cnt++;
    if (lat !== 26) $display("FAIL b2b_latency: got %0d expected 26", lat);
    else pass_cnt++;
  endtask

  task automatic test_specials();
    int lat; logic bok;
    @(posedge clk); @(negedge clk);
    run_op(32'h00000000, 32'hC0000000, lat, bok);
    chk32("zero_result", result, 32'h80000000);
    total_cnt++;
    if (lat !== 1) $display("FAIL zero_latency: got %0d expected 1", lat);
    else pass_cnt++;
    @(posedge clk); @(negedge clk);
    run_op(32'h7F800000, 32'h3F800000, lat, bok);
    chk32("inf_result", result, 32'h7F800000);
    total_cnt++;
    if ({ovf, uff} !== 2'b00) $display("FAIL inf_flags: got %b%b expected 00", ovf, uff);
    else pass_cnt++;
  endtask

  task automatic test_flags();
    int lat; logic bok;
    @(posedge clk); @(negedge clk);
    run_op(32'h7F000000, 32'h40000000, lat, bok);
    chk32("ovf_result", result, 32'h7F800000);
    total_cnt++;
    if ({ovf, uff} !== 2'b10) $display("FAIL ovf_flags: got %b%b expected 10", ovf, uff);
    else pass_cnt++;
    @(posedge clk); @(negedge clk);
    run_op(32'h00800000, 32'h3F000000, lat, bok);
    chk32("uff_result", result, 32'h00000000);
    total_cnt++;
    if ({ovf, uff} !== 2'b01) $display("FAIL uff_flags: got %b%b expected 01", ovf, uff);
    else pass_cnt++;
    @(posedge clk); @(negedge clk);
    total_cnt++;
    if ({result, uff} !== {32'h0, 1'b1}) $display("FAIL uff_hold: got %h %b expected 00000000 1", result, uff);
    else pass_cnt++;
  endtask

  task automatic test_start_held();
    int lat; logic idle_ok;
    start = 1'b1; opa = 32'h3FC00000; opb = 32'h40000000;
    @(posedge clk); lat = 1;
    @(negedge clk);
    while (!done && lat < 40) begin
      if (lat == 5) begin opa = 32'h40400000; opb = 32'h40400000; end
      @(posedge clk); lat++;
      @(negedge clk);
    end
    start = 1'b0;
    chk32("held_result", result, 32'h40400000);
    total_cnt++;
    if (lat !== 26) $display("FAIL held_latency: got %0d expected 26", lat);
    else pass_cnt++;
    idle_ok = 1'b1;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      if (busy || done) idle_ok = 1'b0;
    end
    total_cnt++;
    if (idle_ok !== 1'b1) $display("FAIL held_no_second_op: got busy/done activity expected idle");
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int lat; logic bok;
    start = 1'b1; opa = 32'h40400000; opb = 32'h40400000;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b expected 1", busy);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    total_cnt++;
    if ({busy, done, result, ovf, uff} !== 36'h0)
      $display("FAIL midrst_state: got busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
    else pass_cnt++;
    run_op(32'h3FC00000, 32'h40000000, lat, bok);
    chk32("post_reset_result", result, 32'h40400000);
    total_cnt++;
    if (lat !== 26) $display("FAIL post_reset_latency: got %0d expected 26", lat);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_specials();
    test_flags();
    test_start_held();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
